// File: rtl/usb_line_receiver.sv
// usb_line_receiver: gathers host-to-device bytes into a line buffer with
// backspace editing and replays each completed line as a framed byte stream.
module usb_line_receiver #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic [7:0]       uart_out_data,
  input  logic             uart_out_valid,
  output logic             uart_out_ready,
  output logic [7:0]       line_data,
  output logic             line_valid,
  output logic             line_last,
  input  logic             line_ready,
  output logic [LEN_W-1:0] line_len,
  output logic             line_overflow,
  output logic             busy
);

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_DEL = 8'h7F;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             lovf_q, lovf_d;
  logic [7:0]       line_buf_q [MAX_LEN];
  logic             buf_we;

  logic byte_acc;
  logic line_acc;
  logic is_term;
  logic is_erase;

  // Handshakes and byte classification.
  assign uart_out_ready = (state_q == COLLECT) & ~reset;
  assign byte_acc       = uart_out_valid & uart_out_ready;
  assign line_acc       = line_valid & line_ready;
  assign is_term        = (uart_out_data == CH_CR) || (uart_out_data == CH_LF);
  assign is_erase       = (uart_out_data == CH_BS) || (uart_out_data == CH_DEL);

  // Presentation side: only meaningful while draining a captured line.
  assign busy          = (state_q == DRAIN);
  assign line_valid    = (state_q == DRAIN);
  assign line_last     = (state_q == DRAIN) && (rd_ptr_q == (len_q - 1'b1));
  assign line_data     = line_buf_q[rd_ptr_q[IDX_W-1:0]];
  assign line_len      = len_q;
  assign line_overflow = lovf_q;

  // Next-state logic for collection, editing and drain sequencing.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    len_d    = len_q;
    lovf_d   = lovf_q;
    buf_we   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (byte_acc) begin
          if (is_term) begin
            // A terminator on an empty buffer covers CRLF pairs and blank lines.
            if (wr_cnt_q != '0) begin
              len_d    = wr_cnt_q;
              lovf_d   = ovf_q;
              rd_ptr_d = '0;
              state_d  = DRAIN;
            end
          end else if (is_erase) begin
            // Overflow flag stays sticky even if the line is edited back.
            if (wr_cnt_q != '0) begin
              wr_cnt_d = wr_cnt_q - 1'b1;
            end
          end else if (wr_cnt_q < MAX_CNT) begin
            buf_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (line_acc) begin
          if (line_last) begin
            state_d  = COLLECT;
            wr_cnt_d = '0;
            ovf_d    = 1'b0;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Control state with asynchronous reset; a reset drops any line in flight.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q  <= COLLECT;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      len_q    <= '0;
      lovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      len_q    <= len_d;
      lovf_q   <= lovf_d;
    end
  end

  // Line storage is data only and is never reset.
  always_ff @(posedge clk_48mhz) begin
    if (buf_we) begin
      line_buf_q[wr_cnt_q[IDX_W-1:0]] <= uart_out_data;
    end
  end

endmodule

// File: tb/tb_usb_line_receiver.sv
// Directed bench for usb_line_receiver: line framing, backpressure,
// overflow, exact fit, editing and asynchronous reset during a drain.
module tb_usb_line_receiver;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic             clk_48mhz = 1'b0;
  logic             reset;
  logic [7:0]       uart_out_data;
  logic             uart_out_valid;
  logic             uart_out_ready;
  logic [7:0]       line_data;
  logic             line_valid;
  logic             line_last;
  logic             line_ready;
  logic [LEN_W-1:0] line_len;
  logic             line_overflow;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] expq[$];

  usb_line_receiver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk_48mhz      (clk_48mhz),
    .reset          (reset),
    .uart_out_data  (uart_out_data),
    .uart_out_valid (uart_out_valid),
    .uart_out_ready (uart_out_ready),
    .line_data      (line_data),
    .line_valid     (line_valid),
    .line_last      (line_last),
    .line_ready     (line_ready),
    .line_len       (line_len),
    .line_overflow  (line_overflow),
    .busy           (busy)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_48mhz);
    #1;
  endtask

  // Offer one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int guard;
    uart_out_data  = b;
    uart_out_valid = 1'b1;
    guard = 0;
    while (!uart_out_ready && guard < 200) begin
      step();
      guard++;
    end
    check("rdy_wait", {31'd0, uart_out_ready}, 32'd1);
    step();
    uart_out_valid = 1'b0;
  endtask

  task automatic send_rep(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b);
  endtask

  // Drain the presented frame with line_ready=1, checking every beat against expq.
  task automatic drain_expect(input string tag, input int elen, input bit eovf);
    line_ready = 1'b1;
    for (int i = 0; i < expq.size(); i++) begin
      check({tag, "_valid"}, {31'd0, line_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, line_data}, {24'd0, expq[i]});
      check({tag, "_last"}, {31'd0, line_last}, (i == expq.size() - 1) ? 32'd1 : 32'd0);
      check({tag, "_len"}, {26'd0, line_len}, elen);
      check({tag, "_ovf"}, {31'd0, line_overflow}, {31'd0, eovf});
      check({tag, "_urdy"}, {31'd0, uart_out_ready}, 32'd0);
      step();
    end
    line_ready = 1'b0;
    check({tag, "_end_valid"}, {31'd0, line_valid}, 32'd0);
    check({tag, "_end_urdy"}, {31'd0, uart_out_ready}, 32'd1);
    check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    uart_out_data  = 8'h00;
    uart_out_valid = 1'b0;
    line_ready     = 1'b0;
    #1;
    // Reset state
    check("rst_valid", {31'd0, line_valid}, 32'd0);
    check("rst_last", {31'd0, line_last}, 32'd0);
    check("rst_ovf", {31'd0, line_overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_urdy", {31'd0, uart_out_ready}, 32'd0);
    check("rst_len", {26'd0, line_len}, 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("post_rst_urdy", {31'd0, uart_out_ready}, 32'd1);

    // Basic line "hi\r\n"
    send_byte(8'h68);
    send_byte(8'h69);
    send_byte(8'h0D);
    expq = '{8'h68, 8'h69};
    drain_expect("hi", 2, 1'b0);
    send_byte(8'h0A);
    step();
    check("lf_nofrm", {31'd0, line_valid}, 32'd0);
    check("lf_len_hold", {26'd0, line_len}, 32'd2);

    // Backpressure on "abc\r"
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h63);
    send_byte(8'h0D);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, line_valid}, 32'd1);
      check("bp_data", {24'd0, line_data}, 32'h61);
      check("bp_last", {31'd0, line_last}, 32'd0);
      check("bp_len", {26'd0, line_len}, 32'd3);
      check("bp_urdy", {31'd0, uart_out_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      step();
    end
    line_ready     = 1'b1;
    uart_out_data  = 8'h78;
    uart_out_valid = 1'b1;
    check("bp_b0", {24'd0, line_data}, 32'h61);
    step();
    check("bp_b1", {24'd0, line_data}, 32'h62);
    check("bp_b1_urdy", {31'd0, uart_out_ready}, 32'd0);
    step();
    check("bp_b2", {24'd0, line_data}, 32'h63);
    check("bp_b2_last", {31'd0, line_last}, 32'd1);
    step();
    check("bp_after_valid", {31'd0, line_valid}, 32'd0);
    check("bp_after_urdy", {31'd0, uart_out_ready}, 32'd1);
    line_ready = 1'b0;
    step();
    uart_out_valid = 1'b0;
    send_byte(8'h0D);
    expq = '{8'h78};
    drain_expect("bp_x", 1, 1'b0);

    // Overflow: 40 x 'A' then CR
    send_rep(8'h41, 40);
    send_byte(8'h0D);
    expq = {};
    for (int i = 0; i < 32; i++) expq.push_back(8'h41);
    drain_expect("ovf", 32, 1'b1);
    send_byte(8'h7A);
    send_byte(8'h0D);
    expq = '{8'h7A};
    drain_expect("ovf_z", 1, 1'b0);

    // Exact fit: 32 x 'B' then LF
    send_rep(8'h42, 32);
    send_byte(8'h0A);
    expq = {};
    for (int i = 0; i < 32; i++) expq.push_back(8'h42);
    drain_expect("fit", 32, 1'b0);

    // Editing "ab\x08c\r"
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h08);
    send_byte(8'h63);
    send_byte(8'h0D);
    expq = '{8'h61, 8'h63};
    drain_expect("edit", 2, 1'b0);
    send_byte(8'h7F);
    send_byte(8'h0D);
    step();
    step();
    check("del_nofrm", {31'd0, line_valid}, 32'd0);
    check("del_urdy", {31'd0, uart_out_ready}, 32'd1);
    check("del_len_hold", {26'd0, line_len}, 32'd2);

    // Async reset mid-drain on "xyz\r"
    send_byte(8'h78);
    send_byte(8'h79);
    send_byte(8'h7A);
    send_byte(8'h0D);
    check("ar_b0", {24'd0, line_data}, 32'h78);
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    check("ar_b1", {24'd0, line_data}, 32'h79);
    check("ar_b1_valid", {31'd0, line_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", {31'd0, line_valid}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_last", {31'd0, line_last}, 32'd0);
    check("ar_urdy", {31'd0, uart_out_ready}, 32'd0);
    check("ar_len", {26'd0, line_len}, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("ar_rel_valid", {31'd0, line_valid}, 32'd0);
    send_byte(8'h71);
    send_byte(8'h0D);
    expq = '{8'h71};
    drain_expect("ar_q", 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/usb_line_receiver.md
Name: usb_line_receiver

Overview:
- Consumes the host-to-device byte stream from the usb_uart `uart_out_*` pipeline.
- Assembles bytes into a line buffer, with simple backspace editing.
- On a CR/LF terminator, presents the completed line as a framed byte stream with valid/ready/last.
- Downstream command parsers consume whole lines instead of single bytes; it is the receive-side counterpart of the text transmitter logic.

Parameters:
- MAX_LEN, 32, maximum stored bytes per line (excluding terminator).
- LEN_W, 6, width of length/pointer fields; must satisfy 2**LEN_W > MAX_LEN.

Ports:
- clk_48mhz  input  1  sole clock, 48 MHz USB domain.
- reset  input  1  asynchronous, active-high reset.
- uart_out_data  input  8  byte from usb_uart.
- uart_out_valid  input  1  byte on uart_out_data is valid.
- uart_out_ready  output  1  block accepts byte this cycle.
- line_data  output  8  current line byte.
- line_valid  output  1  line_data is valid.
- line_last  output  1  line_data is the final byte of the line.
- line_ready  input  1  downstream accepts line_data.
- line_len  output  LEN_W  byte count of the line being presented.
- line_overflow  output  1  presented line was truncated.
- busy  output  1  high while in DRAIN.

Behaviour:
- Clocking and reset:
  - One clock, clk_48mhz. reset is asynchronous and active-high.
  - On reset: state=COLLECT, wr_cnt=0, rd_ptr=0, ovf=0, line_len=0.
  - Outputs during reset: line_valid=0, line_last=0, line_overflow=0, busy=0, uart_out_ready=0.
  - The buffer contents are not reset.
- Handshakes:
  - A byte transfers on a rising edge with uart_out_valid & uart_out_ready.
  - A line byte transfers on a rising edge with line_valid & line_ready.
- uart_out_ready = (state==COLLECT) & ~reset, combinational.
- State COLLECT, per accepted byte b:
  - b==0x0D or b==0x0A with wr_cnt==0: discard. This covers CRLF pairs and empty lines. No state change.
  - b==0x0D or b==0x0A with wr_cnt>0: line_len<=wr_cnt, line_overflow<=ovf, rd_ptr<=0, state<=DRAIN.
  - b==0x08 or b==0x7F: if wr_cnt>0, wr_cnt<=wr_cnt-1, else no effect. ovf is unchanged (sticky for the line).
  - Any other b with wr_cnt<MAX_LEN: buf[wr_cnt]<=b, wr_cnt<=wr_cnt+1.
  - Any other b with wr_cnt==MAX_LEN: byte dropped, ovf<=1.
- State DRAIN:
  - busy=1, line_valid=1, line_data=buf[rd_ptr], line_last=(rd_ptr==line_len-1). uart_out_ready=0, so usb_uart holds pending bytes.
  - First line_valid is high in the cycle immediately after the terminator-accept edge. Latency is 1 cycle.
  - On a line handshake that is not last: rd_ptr<=rd_ptr+1.
  - On a line handshake with line_last: state<=COLLECT, wr_cnt<=0, ovf<=0, rd_ptr<=0.
  - line_valid falls the next cycle; uart_out_ready rises that same cycle.
  - line_data, line_last, line_len and line_overflow stay stable while line_valid & ~line_ready.
- Outside DRAIN:
  - line_valid=0, line_last=0.
  - line_len and line_overflow hold their last values.
- Widths and limits:
  - wr_cnt and rd_ptr are LEN_W bits and never exceed MAX_LEN, so there is no wrap-around.
  - Line length is always in 1..MAX_LEN.
- Reset mid-operation: the in-progress or presented line is discarded immediately (asynchronously); no partial frame resumes.
- uart_out_data is ignored whenever uart_out_valid=0 or state==DRAIN.

Test Plan:
- Basic line: send "hi\r\n" with line_ready=1.
  - Expect a 2-beat frame 0x68 then 0x69, line_last only on 0x69, line_len=2, line_overflow=0.
  - The LF produces no second frame.
- Backpressure: send "abc\r" and hold line_ready=0 for 5 cycles after the first beat.
  - line_data holds 0x61 stably and uart_out_ready=0 throughout DRAIN.
  - A byte offered at the end is accepted the cycle after the 0x63 last-beat handshake.
- Overflow: with MAX_LEN=32, send 40×'A' then "\r".
  - Expect exactly 32 beats of 0x41, line_len=32, line_overflow=1.
  - A following "z\r" yields a 1-beat frame with line_overflow=0.
- Exact fit: send 32×'B' then "\n".
  - Expect 32 beats, line_len=32, line_overflow=0.
- Editing: send "ab\x08c\r".
  - Expect 0x61, 0x63 with line_len=2.
  - Then send "\x7F\r" on an empty buffer: expect no frame.
- Async reset mid-drain: send "xyz\r", accept one beat, assert reset between clock edges.
  - line_valid drops immediately.
  - After release, "q\r" produces a single 0x71 frame with line_last=1 and line_len=1.
